aes_axil_regs: RTL and testbench
================================

Name: aes_axil_regs

Overview:
- AXI4-Lite responder (slave) register file for the AES-CTR streaming core; the target side of the AXI-Lite config initiator.
- Holds the 128-bit key, the 128-bit nonce/IV and a control word, and drives them to the AES datapath.
- Returns status and block count to software.
- Single outstanding write and single outstanding read; no bursts.

Parameters:
- ADDR_W, 6, AXI-Lite address width (byte address).
- VERSION, 32'h0001_0000, read-only value at 0x2C.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_awaddr  in  ADDR_W  write address
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  byte strobes
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_araddr  in  ADDR_W  read address
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read data valid
- s_axil_rready  in  1  read data ready
- key  out  128  AES key
- iv  out  128  CTR nonce/IV
- enable  out  1  core enable (CTRL[1])
- start_pulse  out  1  one-cycle start strobe
- core_busy  in  1  core busy status
- core_done  in  1  single-cycle done event
- block_count  in  32  blocks processed

Behaviour:
- Reset values:
  - key, iv, enable, start_pulse, bvalid, rvalid, done_sticky = 0; bresp, rresp, rdata = 0.
  - AW/W latches empty, so awready = wready = arready = 1.
- Register map (addr[1:0] ignored; word index = addr[5:2]):
  - 0x00 CTRL RW: bit0 START (write-1 pulse, reads 0), bit1 ENABLE.
  - 0x04 STATUS: bit0 busy (RO, live core_busy); bit1 done (sticky, W1C).
  - 0x08/0x0C/0x10/0x14 KEY0..3 RW; KEY0 = key[127:96] … KEY3 = key[31:0].
  - 0x18/0x1C/0x20/0x24 IV0..3 RW; same word order as KEY.
  - 0x28 BLKCNT RO = block_count.
  - 0x2C VERSION RO.
  - 0x30–0x3C unmapped.
- Write channel:
  - AW and W accepted independently, in either order or in the same cycle.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Commit happens in the cycle both address and data are held (or arrive). bvalid rises the next cycle and the latches clear.
  - bvalid holds until bready; the next AW/W is accepted only after the B handshake completes.
  - Byte lanes are updated only where wstrb[i] = 1.
- Responses:
  - Mapped RW or RO register: OKAY (2'b00); writes to RO bits are ignored.
  - Unmapped address: SLVERR (2'b10) on either channel, no side effect; unmapped reads return 0.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, rdata/rresp are registered and rvalid rises the next cycle (1-cycle latency).
  - rdata is held stable until rready.
  - A read and a write to the same register in the same cycle returns the pre-write value.
- start_pulse: high exactly one cycle, in the cycle after a committed CTRL write with wdata[0] = 1 and wstrb[0] = 1. Independent of the ENABLE value.
- done_sticky:
  - Set by core_done.
  - Cleared by a STATUS write with wdata[1] = 1 and wstrb[0] = 1.
  - If set and clear occur in the same cycle, set wins.
- Reset asserted mid-transaction: all state clears immediately. Outstanding responses are dropped and key/iv return to 0.

Test Plan:
- Write 0x08..0x14 = 2B7E1516, 28AED2A6, ABF71588, 09CF4F3C with AW and W in the same cycle → each bresp = 0, key = 2B7E151628AED2A6ABF7158809CF4F3C; readback matches.
- W presented 3 cycles before AW, and a separate case AW before W; IV0 = DEADBEEF, wstrb = 4'b0011 → IV0 reads 0000BEEF; bvalid rises exactly 1 cycle after the second handshake.
- bready held low 5 cycles → bvalid stays 1, awready = wready = 0 throughout; a second write is accepted only after the B handshake.
- Write CTRL = 3 → start_pulse high exactly 1 cycle, enable = 1; read CTRL returns 2.
- Pulse core_done, read STATUS → 2; write STATUS = 2 in the same cycle as a core_done pulse → next read still 2; write STATUS = 2 alone → read 0.
- Read 0x34 → rresp = 2'b10, rdata = 0; write 0x30 → bresp = 2'b10; read 0x2C → 00010000; reset asserted with bvalid high → bvalid = 0 and key = 0 immediately.

Source files
------------

// File: rtl/aes_axil_regs.sv
// AXI4-Lite register file for the AES-CTR core: key, IV, control, status and block count.
// Writes commit once both AW and W are held; B and R responses are registered and held until accepted.
module aes_axil_regs #(
    parameter int          ADDR_W  = 6,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [127:0]      key,
    output logic [127:0]      iv,
    output logic              enable,
    output logic              start_pulse,
    input  logic              core_busy,
    input  logic              core_done,
    input  logic [31:0]       block_count
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] IDX_CTRL    = 4'd0;
    localparam logic [3:0] IDX_STATUS  = 4'd1;
    localparam logic [3:0] IDX_LAST    = 4'd11;

    logic              aw_held;
    logic [ADDR_W-1:0] aw_addr;
    logic              w_held;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              done_sticky;

    logic              aw_fire;
    logic              w_fire;
    logic              ar_fire;
    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [3:0]        wr_idx;
    logic              wr_map;
    logic [3:0]        rd_idx;
    logic              rd_map;
    logic [31:0]       rd_word;
    logic              unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    assign s_axil_awready = !aw_held && !s_axil_bvalid;
    assign s_axil_wready  = !w_held  && !s_axil_bvalid;
    assign s_axil_arready = !s_axil_rvalid;

    assign aw_fire = s_axil_awvalid && s_axil_awready;
    assign w_fire  = s_axil_wvalid  && s_axil_wready;
    assign ar_fire = s_axil_arvalid && s_axil_arready;

    // A write commits in the cycle both halves are available, whether latched earlier or arriving now.
    assign commit  = (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_addr = aw_held ? aw_addr : s_axil_awaddr;
    assign wr_data = w_held  ? w_data  : s_axil_wdata;
    assign wr_strb = w_held  ? w_strb  : s_axil_wstrb;

    assign wr_idx  = wr_addr[5:2];
    assign wr_map  = ((wr_addr >> 6) == '0) && (wr_idx <= IDX_LAST);
    assign rd_idx  = s_axil_araddr[5:2];

    assign unused_addr_bits = ^{wr_addr[1:0], s_axil_araddr[1:0]};

    always_comb begin
        rd_word = '0;
        rd_map  = 1'b1;
        case (rd_idx)
            4'd0:    rd_word = {30'd0, enable, 1'b0};
            4'd1:    rd_word = {30'd0, done_sticky, core_busy};
            4'd2:    rd_word = key[127:96];
            4'd3:    rd_word = key[95:64];
            4'd4:    rd_word = key[63:32];
            4'd5:    rd_word = key[31:0];
            4'd6:    rd_word = iv[127:96];
            4'd7:    rd_word = iv[95:64];
            4'd8:    rd_word = iv[63:32];
            4'd9:    rd_word = iv[31:0];
            4'd10:   rd_word = block_count;
            4'd11:   rd_word = VERSION;
            default: rd_map  = 1'b0;
        endcase
        if ((s_axil_araddr >> 6) != '0) begin
            rd_word = '0;
            rd_map  = 1'b0;
        end
    end

    // Write channel: independent AW/W latches, single outstanding B response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held       <= 1'b0;
            aw_addr       <= '0;
            w_held        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_map ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_fire) begin
                    aw_held <= 1'b1;
                    aw_addr <= s_axil_awaddr;
                end
                if (w_fire) begin
                    w_held <= 1'b1;
                    w_data <= s_axil_wdata;
                    w_strb <= s_axil_wstrb;
                end
                if (s_axil_bready) s_axil_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data captured at the AR handshake, so a same-cycle write is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (ar_fire) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_word;
            s_axil_rresp  <= rd_map ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key    <= '0;
            iv     <= '0;
            enable <= 1'b0;
        end else if (commit && wr_map) begin
            case (wr_idx)
                4'd0:    if (wr_strb[0]) enable <= wr_data[1];
                4'd2:    key[127:96] <= merge_bytes(key[127:96], wr_data, wr_strb);
                4'd3:    key[95:64]  <= merge_bytes(key[95:64],  wr_data, wr_strb);
                4'd4:    key[63:32]  <= merge_bytes(key[63:32],  wr_data, wr_strb);
                4'd5:    key[31:0]   <= merge_bytes(key[31:0],   wr_data, wr_strb);
                4'd6:    iv[127:96]  <= merge_bytes(iv[127:96],  wr_data, wr_strb);
                4'd7:    iv[95:64]   <= merge_bytes(iv[95:64],   wr_data, wr_strb);
                4'd8:    iv[63:32]   <= merge_bytes(iv[63:32],   wr_data, wr_strb);
                4'd9:    iv[31:0]    <= merge_bytes(iv[31:0],    wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    // A done event arriving with a W1C clear must not be lost, so set has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pulse <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            start_pulse <= commit && wr_map && (wr_idx == IDX_CTRL) && wr_strb[0] && wr_data[0];
            if (core_done) begin
                done_sticky <= 1'b1;
            end else if (commit && wr_map && (wr_idx == IDX_STATUS) && wr_strb[0] && wr_data[1]) begin
                done_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_axil_regs.sv
// Scoreboard bench for aes_axil_regs: driver pushes expected B/R responses, a negedge monitor pops them.
module tb_aes_axil_regs;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] s_axil_awaddr;
    logic              s_axil_awvalid;
    logic              s_axil_awready;
    logic [31:0]       s_axil_wdata;
    logic [3:0]        s_axil_wstrb;
    logic              s_axil_wvalid;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready;
    logic [ADDR_W-1:0] s_axil_araddr;
    logic              s_axil_arvalid;
    logic              s_axil_arready;
    logic [31:0]       s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready;
    logic [127:0]      key;
    logic [127:0]      iv;
    logic              enable;
    logic              start_pulse;
    logic              core_busy;
    logic              core_done;
    logic [31:0]       block_count;

    aes_axil_regs #(.ADDR_W(ADDR_W), .VERSION(32'h0001_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .key(key), .iv(iv), .enable(enable), .start_pulse(start_pulse),
        .core_busy(core_busy), .core_done(core_done), .block_count(block_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    // Reference model: register contents as plain words.
    logic [31:0] mk[4];
    logic [31:0] mi[4];
    logic        m_en;
    logic        m_done;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mk[i] = '0;
            mi[i] = '0;
        end
        m_en   = 1'b0;
        m_done = 1'b0;
    endtask

    function automatic logic [31:0] apply_strb(input logic [31:0] old_word, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                               input bit with_done, output logic [1:0] resp, output logic st);
        int idx;
        idx  = int'(a) / 4;
        resp = 2'b00;
        st   = 1'b0;
        if (idx > 11) resp = 2'b10;
        else if (idx == 0) begin
            if (s[0]) begin
                m_en = d[1];
                st   = d[0];
            end
        end else if (idx == 1) begin
            if (s[0] && d[1]) m_done = 1'b0;
        end else if (idx >= 2 && idx <= 5) mk[idx-2] = apply_strb(mk[idx-2], d, s);
        else if (idx >= 6 && idx <= 9) mi[idx-6] = apply_strb(mi[idx-6], d, s);
        if (with_done) m_done = 1'b1;
    endtask

    function automatic logic [33:0] model_read(input logic [ADDR_W-1:0] a);
        int idx;
        idx = int'(a) / 4;
        if (idx == 0)                  return {2'b00, 30'd0, m_en, 1'b0};
        if (idx == 1)                  return {2'b00, 30'd0, m_done, core_busy};
        if (idx >= 2 && idx <= 5)      return {2'b00, mk[idx-2]};
        if (idx >= 6 && idx <= 9)      return {2'b00, mi[idx-6]};
        if (idx == 10)                 return {2'b00, block_count};
        if (idx == 11)                 return {2'b00, 32'h0001_0000};
        return {2'b10, 32'd0};
    endfunction

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first; 0: same cycle.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lead, input bit with_done);
        logic [1:0] er;
        logic       es;
        bit aw_ok, w_ok, aw_hs, w_hs;
        int cyc;
        model_write(a, d, s, with_done, er, es);
        exp_b.push_back(er);
        @(posedge clk); #1;
        if (with_done) core_done = 1'b1;
        if (lead >= 0) begin s_axil_wvalid = 1'b1; s_axil_wdata = d; s_axil_wstrb = s; end
        if (lead <= 0) begin s_axil_awvalid = 1'b1; s_axil_awaddr = a; end
        aw_ok = 0; w_ok = 0; cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 60) begin
            @(negedge clk);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            @(posedge clk); #1;
            cyc++;
            core_done = 1'b0;
            if (aw_hs) begin aw_ok = 1; s_axil_awvalid = 1'b0; end
            if (w_hs)  begin w_ok = 1;  s_axil_wvalid = 1'b0; end
            if (lead > 0 && cyc == lead && !aw_ok) begin s_axil_awvalid = 1'b1; s_axil_awaddr = a; end
            if (lead < 0 && cyc == -lead && !w_ok) begin
                s_axil_wvalid = 1'b1; s_axil_wdata = d; s_axil_wstrb = s;
            end
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        chk("write_handshake", {aw_ok, w_ok}, 2'b11);
        @(negedge clk);
        chk("bvalid_latency", s_axil_bvalid, 1'b1);
        chk("start_pulse", start_pulse, es);
        chk("key_out", key, {mk[0], mk[1], mk[2], mk[3]});
        chk("iv_out", iv, {mi[0], mi[1], mi[2], mi[3]});
        chk("enable_out", enable, m_en);
        @(negedge clk);
        chk("start_pulse_clear", start_pulse, 1'b0);
    endtask

    task automatic rd_drive(input logic [ADDR_W-1:0] a);
        bit hs;
        int cyc;
        hs = 0; cyc = 0;
        @(posedge clk); #1;
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = a;
        while (!hs && cyc < 60) begin
            @(negedge clk);
            hs = s_axil_arvalid && s_axil_arready;
            @(posedge clk); #1;
            cyc++;
        end
        s_axil_arvalid = 1'b0;
        chk("read_handshake", hs, 1'b1);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        exp_r.push_back(model_read(a));
        rd_drive(a);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        m_done = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_axil_bvalid && s_axil_bready) begin
                if (exp_b.size() == 0) chk("unexpected_b", 1'b1, 1'b0);
                else chk("bresp", s_axil_bresp, exp_b.pop_front());
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (exp_r.size() == 0) chk("unexpected_r", 1'b1, 1'b0);
                else chk("rresp_rdata", {s_axil_rresp, s_axil_rdata}, exp_r.pop_front());
            end
        end
    end

    logic [33:0] pre;

    initial begin
        rst_n = 1'b0;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
        s_axil_wvalid = 1'b0; s_axil_bready = 1'b1; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b1; core_busy = 1'b0; core_done = 1'b0; block_count = 32'h0000_0123;
        model_reset();
        #22;
        chk("rst_awready", s_axil_awready, 1'b1);
        chk("rst_wready", s_axil_wready, 1'b1);
        chk("rst_arready", s_axil_arready, 1'b1);
        chk("rst_valids", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
        chk("rst_resp_data", {s_axil_bresp, s_axil_rresp, s_axil_rdata}, 36'd0);
        chk("rst_key_iv", {key, iv}, 256'd0);
        chk("rst_ctrl", {enable, start_pulse}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        wr(6'h08, 32'h2B7E1516, 4'hF, 0, 0);
        wr(6'h0C, 32'h28AED2A6, 4'hF, 0, 0);
        wr(6'h10, 32'hABF71588, 4'hF, 0, 0);
        wr(6'h14, 32'h09CF4F3C, 4'hF, 0, 0);
        chk("aes_key", key, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
        for (int i = 0; i < 4; i++) rd(6'(8 + 4*i));

        wr(6'h18, 32'hDEADBEEF, 4'b0011, 3, 0);
        rd(6'h18);
        wr(6'h18, 32'h0, 4'hF, 0, 0);
        wr(6'h18, 32'hDEADBEEF, 4'b0011, -3, 0);
        rd(6'h18);
        chk("iv0_partial", iv[127:96], 32'h0000BEEF);

        s_axil_bready = 1'b0;
        wr(6'h1C, 32'h1234_5678, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_hold", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b100);
        end
        @(posedge clk); #1;
        s_axil_bready = 1'b1;
        wr(6'h20, 32'hCAFE_F00D, 4'hF, 1, 0);
        rd(6'h1C);

        wr(6'h00, 32'h3, 4'hF, 0, 0);
        chk("enable_set", enable, 1'b1);
        rd(6'h00);

        pulse_done();
        rd(6'h04);
        wr(6'h04, 32'h2, 4'hF, 0, 1);
        rd(6'h04);
        wr(6'h04, 32'h2, 4'hF, 0, 0);
        rd(6'h04);

        rd(6'h34);
        wr(6'h30, 32'hFFFF_FFFF, 4'hF, 0, 0);
        rd(6'h2C);
        rd(6'h28);

        pre = model_read(6'h14);
        exp_r.push_back(pre);
        fork
            rd_drive(6'h14);
            wr(6'h14, 32'h5555_AAAA, 4'hF, 0, 0);
        join
        rd(6'h14);

        s_axil_bready = 1'b0;
        wr(6'h08, 32'h1122_3344, 4'hF, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_bvalid", s_axil_bvalid, 1'b0);
        chk("midrst_key", key, 128'd0);
        chk("midrst_awready", s_axil_awready, 1'b1);
        exp_b.delete();
        model_reset();
        @(posedge clk); #1;
        s_axil_bready = 1'b1;
        rst_n = 1'b1;
        rd(6'h08);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0, 1: wr(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 6)) - 3, 0);
                2, 3: rd(6'($urandom_range(0, 63)));
                default: begin
                    if ($urandom_range(0, 1) == 1) pulse_done();
                    else begin
                        @(posedge clk); #1;
                        core_busy   = 1'($urandom_range(0, 1));
                        block_count = $urandom;
                    end
                end
            endcase
        end

        for (int i = 0; i < 20 && (exp_b.size() + exp_r.size()) != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_b.size() + exp_r.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
